multiplexer_framer: RTL and testbench

Parametrised successor to the 8-bit symbol multiplexer in the physical-layer transmit path. It sequences its own output symbols: it frames upstream TLP bytes with STP/END, fills gaps with IDL, pads stalled packets with PAD, and periodically inserts SKP ordered sets between packets. It emits one 8-bit symbol per enabled clock, with a K-flag, to the encoder stage.

---
 rtl/multiplexer_framer.sv | 133 +++++++++++++
 tb/tb_multiplexer_framer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multiplexer_framer.sv
// Transmit symbol multiplexer: frames TLP bytes with STP/END, fills with IDL/PAD
// and, when MUX_SKP_EN is defined, inserts periodic COM+SKP ordered sets between packets.
module multiplexer_framer #(
    parameter int unsigned SKP_INTERVAL = 1180,
    parameter int unsigned SKP_LEN      = 3,
    parameter int unsigned CNT_W        = 11,
    parameter logic [7:0]  SYM_COM      = 8'hBC,
    parameter logic [7:0]  SYM_SKP      = 8'h1C,
    parameter logic [7:0]  SYM_STP      = 8'hFB,
    parameter logic [7:0]  SYM_END      = 8'hFD,
    parameter logic [7:0]  SYM_PAD      = 8'hF7,
    parameter logic [7:0]  SYM_IDL      = 8'h7C
) (
    input  logic       muxCLK,
    input  logic       muxRST,
    input  logic       ENB,
    input  logic       tlpVLD,
    input  logic [7:0] tlpDATA,
    input  logic       tlpLAST,
    output logic       tlpRDY,
    output logic [7:0] muxOUT,
    output logic       muxK,
    output logic       muxVLD
);

`ifdef MUX_SKP_EN
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_END, S_SKP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_DATA, S_END} state_t;
`endif

    state_t state;
    logic   skp_due;

    // Bytes are only taken while framing a packet on an enabled cycle.
    assign tlpRDY = (state == S_DATA) && ENB && !muxRST;

`ifdef MUX_SKP_EN
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SKP_INTERVAL - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(SKP_INTERVAL - 2);
    localparam logic [2:0]       SKP_LAST = 3'(SKP_LEN - 1);

    logic [CNT_W-1:0] int_cnt;
    logic [2:0]       skp_cnt;

    // Interval counter saturates at CNT_MAX; the COM edge restarts it.
    always_ff @(posedge muxCLK) begin
        if (muxRST) begin
            int_cnt <= '0;
            skp_due <= 1'b0;
        end else if (ENB) begin
            if (skp_due && (state == S_IDLE)) begin
                int_cnt <= '0;
                skp_due <= 1'b0;
            end else if (int_cnt != CNT_MAX) begin
                int_cnt <= int_cnt + CNT_W'(1);
                if (int_cnt == CNT_PRE) begin
                    skp_due <= 1'b1;
                end
            end
        end
    end
`else
    assign skp_due = 1'b0;
`endif

    // Symbol sequencer; each state selects the source for the next enabled edge.
    always_ff @(posedge muxCLK) begin
        if (muxRST) begin
            state  <= S_IDLE;
            muxOUT <= 8'h00;
            muxK   <= 1'b0;
            muxVLD <= 1'b0;
`ifdef MUX_SKP_EN
            skp_cnt <= 3'd0;
`endif
        end else if (!ENB) begin
            muxOUT <= 8'h00;
            muxK   <= 1'b0;
            muxVLD <= 1'b0;
        end else begin
            muxVLD <= 1'b1;
            muxK   <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (skp_due) begin
                        muxOUT <= SYM_COM;
`ifdef MUX_SKP_EN
                        state   <= S_SKP;
                        skp_cnt <= 3'd0;
`else
                        state   <= S_IDLE;
`endif
                    end else if (tlpVLD) begin
                        muxOUT <= SYM_STP;
                        state  <= S_DATA;
                    end else begin
                        muxOUT <= SYM_IDL;
                    end
                end
                S_DATA: begin
                    if (tlpVLD) begin
                        muxOUT <= tlpDATA;
                        muxK   <= 1'b0;
                        if (tlpLAST) begin
                            state <= S_END;
                        end
                    end else begin
                        muxOUT <= SYM_PAD;
                    end
                end
                S_END: begin
                    muxOUT <= SYM_END;
                    state  <= S_IDLE;
                end
`ifdef MUX_SKP_EN
                S_SKP: begin
                    muxOUT  <= SYM_SKP;
                    skp_cnt <= skp_cnt + 3'd1;
                    if (skp_cnt == SKP_LAST) begin
                        state <= S_IDLE;
                    end
                end
`endif
                default: begin
                    muxOUT <= SYM_IDL;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplexer_framer.sv
// Scoreboard bench for multiplexer_framer: stimulus queues expected symbols,
// a negedge monitor pops and compares whenever muxVLD is high.
module tb_multiplexer_framer;
    localparam logic [7:0] IDL  = 8'h7C;
    localparam logic [7:0] STP  = 8'hFB;
    localparam logic [7:0] ENDS = 8'hFD;
    localparam logic [7:0] PAD  = 8'hF7;
`ifdef MUX_SKP_EN
    localparam logic [7:0] COM  = 8'hBC;
    localparam logic [7:0] SKP  = 8'h1C;
`endif

    logic       muxCLK  = 1'b0;
    logic       muxRST  = 1'b1;
    logic       ENB     = 1'b0;
    logic       tlpVLD  = 1'b0;
    logic [7:0] tlpDATA = 8'h00;
    logic       tlpLAST = 1'b0;
    logic       tlpRDY;
    logic [7:0] muxOUT;
    logic       muxK;
    logic       muxVLD;

    int total = 0;
    int bad   = 0;
    string cur_test = "init";
    logic [8:0] exp_q[$];

    multiplexer_framer #(
        .SKP_INTERVAL(8),
        .SKP_LEN(3),
        .CNT_W(11)
    ) dut (
        .muxCLK (muxCLK),
        .muxRST (muxRST),
        .ENB    (ENB),
        .tlpVLD (tlpVLD),
        .tlpDATA(tlpDATA),
        .tlpLAST(tlpLAST),
        .tlpRDY (tlpRDY),
        .muxOUT (muxOUT),
        .muxK   (muxK),
        .muxVLD (muxVLD)
    );

    always #5 muxCLK = ~muxCLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s/%s: got %0h expected %0h", cur_test, name, act, exp);
        end
    endtask

    always @(negedge muxCLK) begin : monitor
        logic [8:0] e;
        if (muxVLD === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s/unexpected_symbol: got K=%0b %0h expected nothing", cur_test, muxK, muxOUT);
            end else begin
                e = exp_q.pop_front();
                check("symbol", 32'({muxK, muxOUT}), 32'(e));
            end
        end
    end

    // One clock: drive inputs, check tlpRDY, queue the symbol the edge must produce.
    task automatic cyc(input bit en, input bit vld, input logic [7:0] d, input bit last,
                       input bit exp_rdy, input bit exp_k, input logic [7:0] exp_sym);
        ENB     = en;
        tlpVLD  = vld;
        tlpDATA = d;
        tlpLAST = last;
        #1;
        check("rdy", 32'(tlpRDY), 32'(exp_rdy));
        if (en) exp_q.push_back({exp_k, exp_sym});
        @(posedge muxCLK);
        #1;
        if (!en) begin
            check("enb_out", 32'(muxOUT), 32'h0);
            check("enb_k", 32'(muxK), 32'h0);
            check("enb_vld", 32'(muxVLD), 32'h0);
        end
    endtask

    task automatic do_reset(input int n);
        muxRST  = 1'b1;
        ENB     = 1'b1;
        tlpVLD  = 1'b1;
        tlpDATA = 8'h55;
        tlpLAST = 1'b0;
        for (int i = 0; i < n; i++) begin
            #1;
            check("rst_rdy", 32'(tlpRDY), 32'h0);
            @(posedge muxCLK);
            #1;
            check("rst_out", 32'(muxOUT), 32'h0);
            check("rst_k", 32'(muxK), 32'h0);
            check("rst_vld", 32'(muxVLD), 32'h0);
        end
        muxRST = 1'b0;
        tlpVLD = 1'b0;
    endtask

    initial begin
        logic [7:0] idle_exp [16];

        cur_test = "reset";
        do_reset(2);

        cur_test = "idle";
`ifdef MUX_SKP_EN
        idle_exp = '{IDL, IDL, IDL, IDL, IDL, IDL, IDL, COM,
                     SKP, SKP, SKP, IDL, IDL, IDL, IDL, COM};
`else
        for (int i = 0; i < 16; i++) idle_exp[i] = IDL;
`endif
        for (int i = 0; i < 16; i++) cyc(1, 0, 8'h00, 0, 0, 1, idle_exp[i]);

        cur_test = "frame";
        do_reset(1);
        cyc(1, 1, 8'h11, 0, 0, 1, STP);
        cyc(1, 1, 8'h11, 0, 1, 0, 8'h11);
        cyc(1, 1, 8'h22, 0, 1, 0, 8'h22);
        cyc(1, 1, 8'h33, 1, 1, 0, 8'h33);
        cyc(1, 0, 8'h00, 0, 0, 1, ENDS);
        cyc(1, 0, 8'h00, 0, 0, 1, IDL);
        cyc(1, 0, 8'h00, 0, 0, 1, IDL);

        cur_test = "underflow";
        do_reset(1);
        cyc(1, 1, 8'hA0, 0, 0, 1, STP);
        cyc(1, 1, 8'hA0, 0, 1, 0, 8'hA0);
        cyc(1, 0, 8'h00, 0, 1, 1, PAD);
        cyc(1, 0, 8'h00, 0, 1, 1, PAD);
        cyc(1, 1, 8'hA1, 1, 1, 0, 8'hA1);
        cyc(1, 0, 8'h00, 0, 0, 1, ENDS);
        cyc(1, 0, 8'h00, 0, 0, 1, IDL);

        cur_test = "deferral";
        do_reset(1);
        cyc(1, 1, 8'hD0, 0, 0, 1, STP);
        for (int i = 0; i < 10; i++)
            cyc(1, 1, 8'(8'hD0 + i), (i == 9), 1, 0, 8'(8'hD0 + i));
        cyc(1, 1, 8'hE0, 1, 0, 1, ENDS);
`ifdef MUX_SKP_EN
        cyc(1, 1, 8'hE0, 1, 0, 1, COM);
        for (int i = 0; i < 3; i++) cyc(1, 1, 8'hE0, 1, 0, 1, SKP);
`endif
        cyc(1, 1, 8'hE0, 1, 0, 1, STP);
        cyc(1, 1, 8'hE0, 1, 1, 0, 8'hE0);
        cyc(1, 0, 8'h00, 0, 0, 1, ENDS);
        cyc(1, 0, 8'h00, 0, 0, 1, IDL);

        cur_test = "enable";
        do_reset(1);
        cyc(1, 1, 8'hB0, 0, 0, 1, STP);
        cyc(1, 1, 8'hB0, 0, 1, 0, 8'hB0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 8'hB1, 0, 0, 0, 8'h00);
        cyc(1, 1, 8'hB1, 0, 1, 0, 8'hB1);
        cyc(1, 1, 8'hB2, 1, 1, 0, 8'hB2);
        cyc(1, 0, 8'h00, 0, 0, 1, ENDS);
        cyc(1, 0, 8'h00, 0, 0, 1, IDL);

        cur_test = "midreset";
        do_reset(1);
        cyc(1, 1, 8'hC0, 0, 0, 1, STP);
        cyc(1, 1, 8'hC0, 0, 1, 0, 8'hC0);
        cyc(1, 1, 8'hC1, 0, 1, 0, 8'hC1);
        do_reset(1);
        cyc(1, 0, 8'h00, 0, 0, 1, IDL);
        cyc(1, 0, 8'h00, 0, 0, 1, IDL);

        cur_test = "drain";
        ENB    = 1'b0;
        tlpVLD = 1'b0;
        repeat (2) @(negedge muxCLK);
        check("queue_empty", 32'(exp_q.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
